rv32i_seq_ctrl: RTL and testbench
=================================

// Module: rv32i_seq_ctrl
// PURPOSE
//  Parametrised multi-cycle sequencer for the unpipelined RV32I core: FETCH, DECODE, EXECUTE, MEMORYACCESS, WRITEBACK.
//  Over the fixed 5-stage controller it adds: instruction/data memory ready handshakes; optional MEMORYACCESS skip for
//  non-load/store; external halt; memory-wait timeout with error pulse; retired-instruction counter.
//  Sits between decoder/regfile (operands) and ALU/LSU/CSR/writeback (stage enables).
// PARAMETERS
//  XLEN        32  datapath width (inst stays 32 b)
//  SKIP_MEM    1   1: non-load/store goes EXECUTE->WRITEBACK; 0: always visits MEMORYACCESS
//  MEM_TIMEOUT 0   max MEMORYACCESS wait cycles for mem_ack; 0 = wait forever
//  CNT_W       64  width of instret counter
// PORTS
//  clk                 in   1      clock, rising edge
//  rst_n               in   1      asynchronous active-low reset
//  inst                in   32     instruction from instruction memory
//  inst_ack            in   1      inst valid this cycle
//  pc,rs1,rs2,imm      in   XLEN   operand sources
//  opcode_jal,opcode_auipc,opcode_rtype,opcode_branch,opcode_load,opcode_store  in 1 each  decoded from inst_q
//  mem_ack             in   1      data memory completed access
//  halt                in   1      suppress fetch of next instruction
//  inst_q              out  32     registered instruction
//  stage_q             out  3      current stage
//  a,b                 out  XLEN   ALU operands
//  alu_stage,memoryaccess_stage,writeback_stage,csr_stage  out 1 each  stage decodes
//  done_tick           out  1      one-cycle pulse per retired instruction
//  bus_err             out  1      one-cycle pulse on memory timeout
//  instret             out  CNT_W  retired-instruction count
// BEHAVIOUR
//  Encoding: FETCH=0 DECODE=1 EXECUTE=2 MEMORYACCESS=3 WRITEBACK=4; 5..7 -> FETCH next cycle, no other effect.
//  Reset (async, rst_n low): stage_q=FETCH, inst_q=0, instret=0, wait counter=0, bus_err=0.
//   Combinational outputs follow from reset state: done_tick=0, a=b=0.
//  FETCH: if inst_ack && !halt: inst_q<=inst, ->DECODE. Otherwise stay; inst_q holds.
//  DECODE: ->EXECUTE unconditionally (1 cycle for registered regfile read).
//  EXECUTE: a = (jal|auipc) ? pc : rs1; b = (rtype|branch) ? rs2 : imm.
//   Next stage: MEMORYACCESS if (load|store) or SKIP_MEM==0; else WRITEBACK.
//  a,b = 0 in every stage other than EXECUTE (combinational).
//  MEMORYACCESS: non-load/store leaves after 1 cycle. Load/store waits for mem_ack.
//   mem_ack on the first cycle -> leave next edge, min 1 cycle.
//   Wait counter clears on entry and increments each cycle without mem_ack.
//   MEM_TIMEOUT>0 and counter reaches MEM_TIMEOUT-1 without ack: bus_err=1 for 1 cycle (registered), then ->WRITEBACK.
//   mem_ack in the same cycle as expiry: ack wins, no bus_err.
//  WRITEBACK: always ->FETCH after 1 cycle.
//   done_tick = (stage_q==WRITEBACK), combinational.
//   instret increments on done_tick, including after bus_err; wraps 2^CNT_W-1 -> 0.
//  Stage decodes: alu_stage = EXECUTE; memoryaccess_stage = csr_stage = MEMORYACCESS; writeback_stage = WRITEBACK.
//   With SKIP_MEM=1, non-load/store never visit MEMORYACCESS, so csr_stage is then asserted for load/store only.
//   SKIP_MEM=1 therefore requires the CSR unit to commit on writeback_stage; SKIP_MEM=0 keeps CSR on MEMORYACCESS.
//  halt is sampled in FETCH only. An in-flight instruction always completes to WRITEBACK.
//  mem_ack is ignored outside MEMORYACCESS. inst_ack is ignored outside FETCH.
//  Reset mid-instruction: immediate return to FETCH. Partial instruction is not counted.
// TESTING
//  ADD, SKIP_MEM=1, inst_ack=1, rs1=5, rs2=7:
//   -> stages 0,1,2,4,0; a=5 b=7 in EXECUTE; done_tick once; instret=1; 4 cycles.
//  LW, SKIP_MEM=1, mem_ack held low 3 cycles then high:
//   -> MEMORYACCESS lasts 4 cycles; total 8 cycles; no bus_err.
//  SW, MEM_TIMEOUT=4, mem_ack never:
//   -> 4 MEMORYACCESS cycles, bus_err 1-cycle pulse, then WRITEBACK; instret increments.
//  halt=1 in FETCH, inst_ack=1 for 10 cycles:
//   -> stage_q stays 0, inst_q unchanged. Release halt -> DECODE next edge.
//  JAL, pc=0x100, imm=0x20:
//   -> a=0x100 b=0x20 in EXECUTE. SKIP_MEM=0 -> MEMORYACCESS visited for 1 cycle.
//  rst_n low during MEMORYACCESS wait:
//   -> stage_q=0, inst_q=0 asynchronously; instret unchanged from prior count? no: cleared to 0.
//  CNT_W=4: retire 16 instructions -> instret wraps to 0.

Source files
------------

// File: rtl/rv32i_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORYACCESS/WRITEBACK sequencer for the unpipelined RV32I core.
// Adds memory ready handshakes, optional memory-stage skip, fetch halt, memory timeout and an instret counter.
module rv32i_seq_ctrl #(
  parameter int XLEN        = 32,
  parameter int SKIP_MEM    = 1,
  parameter int MEM_TIMEOUT = 0,
  parameter int CNT_W       = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst,
  input  logic             inst_ack,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  imm,
  input  logic             opcode_jal,
  input  logic             opcode_auipc,
  input  logic             opcode_rtype,
  input  logic             opcode_branch,
  input  logic             opcode_load,
  input  logic             opcode_store,
  input  logic             mem_ack,
  input  logic             halt,
  output logic [31:0]      inst_q,
  output logic [2:0]       stage_q,
  output logic [XLEN-1:0]  a,
  output logic [XLEN-1:0]  b,
  output logic             alu_stage,
  output logic             memoryaccess_stage,
  output logic             writeback_stage,
  output logic             csr_stage,
  output logic             done_tick,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    FETCH        = 3'd0,
    DECODE       = 3'd1,
    EXECUTE      = 3'd2,
    MEMORYACCESS = 3'd3,
    WRITEBACK    = 3'd4
  } stage_t;

  // The wait counter only ever needs to reach MEM_TIMEOUT-1; with no timeout it may wrap harmlessly.
  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  stage_t        stage;
  logic [TW-1:0] wait_cnt;
  logic          is_mem;
  logic          timeout_hit;

  assign is_mem      = opcode_load | opcode_store;
  assign timeout_hit = (MEM_TIMEOUT > 0) && (wait_cnt == TW'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage    <= FETCH;
      inst_q   <= '0;
      instret  <= '0;
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      if (stage == WRITEBACK) instret <= instret + CNT_W'(1);
      case (stage)
        FETCH: begin
          if (inst_ack && !halt) begin
            inst_q <= inst;
            stage  <= DECODE;
          end
        end
        DECODE: stage <= EXECUTE;
        EXECUTE: begin
          wait_cnt <= '0;
          if (is_mem || SKIP_MEM == 0) stage <= MEMORYACCESS;
          else                         stage <= WRITEBACK;
        end
        // An ack arriving on the expiry cycle takes priority over the timeout.
        MEMORYACCESS: begin
          if (!is_mem || mem_ack) begin
            stage <= WRITEBACK;
          end else if (timeout_hit) begin
            bus_err <= 1'b1;
            stage   <= WRITEBACK;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        WRITEBACK: stage <= FETCH;
        default:   stage <= FETCH;
      endcase
    end
  end

  assign stage_q            = stage;
  assign alu_stage          = (stage == EXECUTE);
  assign memoryaccess_stage = (stage == MEMORYACCESS);
  assign csr_stage          = (stage == MEMORYACCESS);
  assign writeback_stage    = (stage == WRITEBACK);
  assign done_tick          = (stage == WRITEBACK);
  assign a = (stage == EXECUTE) ? ((opcode_jal | opcode_auipc) ? pc : rs1) : '0;
  assign b = (stage == EXECUTE) ? ((opcode_rtype | opcode_branch) ? rs2 : imm) : '0;

endmodule

// File: tb/tb_rv32i_seq_ctrl.sv
// Directed bench for rv32i_seq_ctrl: one instance with memory skip, timeout 4 and a 4-bit counter,
// a second with memory stage always visited and no timeout.
module tb_rv32i_seq_ctrl;

  localparam logic [5:0] OP_R = 6'b001000;
  localparam logic [5:0] OP_L = 6'b000010;
  localparam logic [5:0] OP_S = 6'b000001;
  localparam logic [5:0] OP_J = 6'b100000;
  localparam logic [31:0] I_ADD = 32'h007302B3;
  localparam logic [31:0] I_LW  = 32'h0002A303;
  localparam logic [31:0] I_SW  = 32'h0062A023;
  localparam logic [31:0] I_X   = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] inst = '0;
  logic        inst_ack = 1'b0, mem_ack = 1'b0, halt = 1'b0;
  logic [31:0] pc = 32'h100, rs1 = 32'd5, rs2 = 32'd7, imm = 32'h20;
  logic [5:0]  op = '0;

  logic [31:0] inst_q, a, b;
  logic [2:0]  stage_q;
  logic        alu_stage, memoryaccess_stage, writeback_stage, csr_stage, done_tick, bus_err;
  logic [3:0]  instret;

  logic [31:0] inst_q0, a0, b0;
  logic [2:0]  stage_q0;
  logic        alu0, ma0, wb0, csr0, done0, be0;
  logic [63:0] instret0;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  rv32i_seq_ctrl #(.XLEN(32), .SKIP_MEM(1), .MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .inst_ack(inst_ack),
    .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm),
    .opcode_jal(op[5]), .opcode_auipc(op[4]), .opcode_rtype(op[3]),
    .opcode_branch(op[2]), .opcode_load(op[1]), .opcode_store(op[0]),
    .mem_ack(mem_ack), .halt(halt), .inst_q(inst_q), .stage_q(stage_q), .a(a), .b(b),
    .alu_stage(alu_stage), .memoryaccess_stage(memoryaccess_stage),
    .writeback_stage(writeback_stage), .csr_stage(csr_stage),
    .done_tick(done_tick), .bus_err(bus_err), .instret(instret)
  );

  rv32i_seq_ctrl #(.XLEN(32), .SKIP_MEM(0), .MEM_TIMEOUT(0), .CNT_W(64)) dut0 (
    .clk(clk), .rst_n(rst_n), .inst(inst), .inst_ack(inst_ack),
    .pc(pc), .rs1(rs1), .rs2(rs2), .imm(imm),
    .opcode_jal(op[5]), .opcode_auipc(op[4]), .opcode_rtype(op[3]),
    .opcode_branch(op[2]), .opcode_load(op[1]), .opcode_store(op[0]),
    .mem_ack(mem_ack), .halt(halt), .inst_q(inst_q0), .stage_q(stage_q0), .a(a0), .b(b0),
    .alu_stage(alu0), .memoryaccess_stage(ma0), .writeback_stage(wb0), .csr_stage(csr0),
    .done_tick(done0), .bus_err(be0), .instret(instret0)
  );

  typedef struct {
    logic        ia, ma, h;
    logic [5:0]  op;
    logic [31:0] inst;
    logic [2:0]  st;
    logic [31:0] a, b;
    logic        done, be;
    logic [31:0] iq;
  } vec_t;

  vec_t tbl[26];

  function automatic vec_t mk(logic ia_i, logic ma_i, logic h_i, logic [5:0] op_i, logic [31:0] in_i,
                              logic [2:0] st_i, logic [31:0] a_i, logic [31:0] b_i,
                              logic dn_i, logic be_i, logic [31:0] iq_i);
    vec_t v;
    v.ia = ia_i; v.ma = ma_i; v.h = h_i; v.op = op_i; v.inst = in_i;
    v.st = st_i; v.a = a_i; v.b = b_i; v.done = dn_i; v.be = be_i; v.iq = iq_i;
    return v;
  endfunction

  // Expected bundle: stage decodes are derived from the expected stage number.
  function automatic logic [127:0] expect_bundle(logic [2:0] st, logic [31:0] ea, logic [31:0] eb,
                                                 logic dn, logic be, logic [31:0] iq);
    return {23'b0, st, ea, eb, dn, be, iq, st == 3'd2, st == 3'd3, st == 3'd4, st == 3'd3};
  endfunction

  function automatic logic [127:0] got_bundle();
    return {23'b0, stage_q, a, b, done_tick, bus_err, inst_q,
            alu_stage, memoryaccess_stage, writeback_stage, csr_stage};
  endfunction

  task automatic check_output(string name, logic [127:0] got, logic [127:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(vec_t v);
    inst_ack = v.ia; mem_ack = v.ma; halt = v.h; op = v.op; inst = v.inst;
  endtask

  task automatic reset_aligned();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    // ADD, LW with ack on the timeout boundary cycle, SW timing out, then halt/idle fetch behaviour.
    tbl[0]  = mk(1,0,0,OP_R,I_ADD, 0,0,0,0,0, 0);
    tbl[1]  = mk(1,0,0,OP_R,I_X,   1,0,0,0,0, I_ADD);
    tbl[2]  = mk(1,0,0,OP_R,I_X,   2,5,7,0,0, I_ADD);
    tbl[3]  = mk(1,1,0,OP_R,I_X,   4,0,0,1,0, I_ADD);
    tbl[4]  = mk(1,0,0,OP_L,I_LW,  0,0,0,0,0, I_ADD);
    tbl[5]  = mk(0,0,0,OP_L,I_X,   1,0,0,0,0, I_LW);
    tbl[6]  = mk(0,1,0,OP_L,I_X,   2,5,32'h20,0,0, I_LW);
    tbl[7]  = mk(0,0,0,OP_L,I_X,   3,0,0,0,0, I_LW);
    tbl[8]  = mk(0,0,0,OP_L,I_X,   3,0,0,0,0, I_LW);
    tbl[9]  = mk(0,0,0,OP_L,I_X,   3,0,0,0,0, I_LW);
    tbl[10] = mk(0,1,0,OP_L,I_X,   3,0,0,0,0, I_LW);
    tbl[11] = mk(0,0,0,OP_L,I_X,   4,0,0,1,0, I_LW);
    tbl[12] = mk(1,0,0,OP_S,I_SW,  0,0,0,0,0, I_LW);
    tbl[13] = mk(0,0,0,OP_S,I_X,   1,0,0,0,0, I_SW);
    tbl[14] = mk(0,0,0,OP_S,I_X,   2,5,32'h20,0,0, I_SW);
    tbl[15] = mk(0,0,0,OP_S,I_X,   3,0,0,0,0, I_SW);
    tbl[16] = mk(0,0,0,OP_S,I_X,   3,0,0,0,0, I_SW);
    tbl[17] = mk(0,0,0,OP_S,I_X,   3,0,0,0,0, I_SW);
    tbl[18] = mk(0,0,0,OP_S,I_X,   3,0,0,0,0, I_SW);
    tbl[19] = mk(0,0,0,OP_S,I_X,   4,0,0,1,1, I_SW);
    tbl[20] = mk(0,0,0,OP_R,I_ADD, 0,0,0,0,0, I_SW);
    tbl[21] = mk(1,0,1,OP_R,I_ADD, 0,0,0,0,0, I_SW);
    tbl[22] = mk(1,0,0,OP_R,I_ADD, 0,0,0,0,0, I_SW);
    tbl[23] = mk(0,1,0,OP_R,I_X,   1,0,0,0,0, I_ADD);
    tbl[24] = mk(0,0,0,OP_R,I_X,   2,5,7,0,0, I_ADD);
    tbl[25] = mk(0,0,0,OP_R,I_X,   4,0,0,1,0, I_ADD);

    #12;
    check_output("reset_state", got_bundle(), expect_bundle(0,0,0,0,0,0));
    check_output("reset_instret", 128'(instret), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      apply_stimulus(tbl[i]);
      #1;
      check_output($sformatf("row%0d", i), got_bundle(),
                   expect_bundle(tbl[i].st, tbl[i].a, tbl[i].b, tbl[i].done, tbl[i].be, tbl[i].iq));
      step();
    end
    check_output("instret_after_table", 128'(instret), 128'(4));

    // Halt holds FETCH even with inst_ack; release moves to DECODE on the next edge.
    halt = 1'b1; inst_ack = 1'b1; inst = I_LW; op = OP_L; mem_ack = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check_output($sformatf("halt_hold%0d", i), {stage_q, inst_q}, {3'd0, I_ADD});
    end
    halt = 1'b0;
    step();
    check_output("halt_release", {stage_q, inst_q}, {3'd1, I_LW});
    inst_ack = 1'b0;
    step(); step(); step();
    check_output("lw_waiting", 128'(stage_q), 128'(3));
    check_output("instret_before_reset", 128'(instret), 128'(4));

    // Asynchronous reset in the middle of a memory wait.
    #2;
    rst_n = 1'b0;
    #1;
    check_output("async_reset", {stage_q, inst_q, instret, bus_err}, {3'd0, 32'd0, 4'd0, 1'b0});
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // JAL on the always-visit-memory instance.
    op = OP_J; inst_ack = 1'b1; inst = 32'h0200006F; mem_ack = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic [2:0] es;
      es = (i == 5) ? 3'd0 : 3'(i);
      check_output($sformatf("jal_stage%0d", i), {stage_q0, done0, be0}, {es, es == 3'd4, 1'b0});
      if (i == 2) check_output("jal_operands", {a0, b0, alu0}, {32'h100, 32'h20, 1'b1});
      if (i == 3) check_output("jal_csr_stage", {ma0, csr0}, 2'b11);
      step();
    end

    // Load on the no-timeout instance waits indefinitely without bus_err.
    op = OP_L; inst_ack = 1'b0;
    step(); step();
    for (int i = 0; i < 20; i++) begin
      check_output($sformatf("wait_forever%0d", i), {stage_q0, be0}, {3'd3, 1'b0});
      step();
    end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check_output("late_ack_wb", {stage_q0, done0, instret0}, {3'd4, 1'b1, 64'd1});
    step();
    check_output("late_ack_count", 128'(instret0), 128'(2));

    // 4-bit instret wraps after 16 retirements.
    reset_aligned();
    op = OP_R; inst_ack = 1'b1; mem_ack = 1'b0; halt = 1'b0;
    for (int i = 0; i < 15 * 4; i++) step();
    check_output("instret_15", 128'(instret), 128'(15));
    for (int i = 0; i < 4; i++) step();
    check_output("instret_wrap", 128'(instret), 128'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
